// File: rtl/relay_arb_pkg.sv
// Shared types and helpers for the relay round-robin arbiter.
// Handshake: a source beat transfers in a cycle where in_empty_n[i] and in_read[i] are both high.
package relay_arb_pkg;

    typedef enum logic {
        ARB_IDLE,
        ARB_BURST
    } arb_state_t;

    // Successor of idx in a ring of n slots.
    function automatic int unsigned rr_next(input int unsigned idx, input int unsigned n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/relay_rr_arbiter_rr_pick.sv
// Rotate-priority encoder: first set req bit scanning start, start+1, ... mod NUM_SRC.
module rr_pick #(
    parameter int NUM_SRC = 4,
    parameter int SRC_W   = 2
) (
    input  logic [NUM_SRC-1:0] req,
    input  logic [SRC_W-1:0]   start,
    output logic               hit,
    output logic [SRC_W-1:0]   idx
);

    logic [SRC_W-1:0] cand;

    always_comb begin
        hit  = 1'b0;
        idx  = '0;
        cand = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            cand = SRC_W'((32'(start) + i) % NUM_SRC);
            if (!hit && req[cand]) begin
                hit = 1'b1;
                idx = cand;
            end
        end
    end

endmodule

// File: rtl/relay_rr_arbiter.sv
// N-to-1 round-robin burst arbiter feeding one relay_station write port.
// The write port is registered, so the downstream almost-full margin must cover one extra beat.
module relay_rr_arbiter
    import relay_arb_pkg::*;
#(
    parameter int NUM_SRC    = 4,
    parameter int DATA_WIDTH = 32,
    parameter int MAX_BURST  = 4,
    parameter int SRC_W      = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_SRC-1:0]            in_empty_n,
    output logic [NUM_SRC-1:0]            in_read,
    input  logic [NUM_SRC*DATA_WIDTH-1:0] in_dout,
    input  logic                          out_full_n,
    output logic                          out_write,
    output logic [DATA_WIDTH-1:0]         out_din,
    output logic [SRC_W-1:0]              out_src
);

    localparam int CNT_W = $clog2(MAX_BURST + 1);
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(MAX_BURST - 1);

    arb_state_t              state_q, state_d;
    logic [SRC_W-1:0]        gnt_q, gnt_d;
    logic [SRC_W-1:0]        rr_ptr_q, rr_ptr_d;
    logic [CNT_W-1:0]        beat_cnt_q, beat_cnt_d;
    logic                    out_write_q, out_write_d;
    logic [DATA_WIDTH-1:0]   out_din_q, out_din_d;
    logic [SRC_W-1:0]        out_src_q, out_src_d;

    logic                    head_valid;
    logic [DATA_WIDTH-1:0]   head_data;
    logic                    pop;
    logic                    burst_done;
    logic [SRC_W-1:0]        pick_start;
    logic                    pick_hit;
    logic [SRC_W-1:0]        pick_idx;

    always_comb begin
        head_valid = 1'b0;
        head_data  = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (gnt_q == SRC_W'(i)) begin
                head_valid = in_empty_n[i];
                head_data  = in_dout[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    assign pop        = (state_q == ARB_BURST) && head_valid && out_full_n && !rst;
    // A stalled grant is never released: a dry source only counts while the sink can accept.
    assign burst_done = (state_q == ARB_BURST) &&
                        ((pop && (beat_cnt_q == LAST_BEAT)) || (out_full_n && !head_valid));

    // One picker serves both the idle scan and the same-cycle rearbitration on release.
    assign pick_start = (state_q == ARB_IDLE) ? rr_ptr_q
                                              : SRC_W'(rr_next(32'(gnt_q), 32'(NUM_SRC)));

    rr_pick #(
        .NUM_SRC (NUM_SRC),
        .SRC_W   (SRC_W)
    ) u_pick (
        .req   (in_empty_n),
        .start (pick_start),
        .hit   (pick_hit),
        .idx   (pick_idx)
    );

    always_comb begin
        for (int i = 0; i < NUM_SRC; i++) begin
            in_read[i] = pop && (gnt_q == SRC_W'(i));
        end
    end

    always_comb begin
        state_d    = state_q;
        gnt_d      = gnt_q;
        rr_ptr_d   = rr_ptr_q;
        beat_cnt_d = beat_cnt_q;
        case (state_q)
            ARB_IDLE: begin
                if (pick_hit) begin
                    state_d    = ARB_BURST;
                    gnt_d      = pick_idx;
                    beat_cnt_d = '0;
                end
            end
            ARB_BURST: begin
                if (pop) begin
                    beat_cnt_d = beat_cnt_q + CNT_W'(1);
                end
                if (burst_done) begin
                    rr_ptr_d   = pick_start;
                    beat_cnt_d = '0;
                    if (pick_hit) begin
                        gnt_d = pick_idx;
                    end else begin
                        state_d = ARB_IDLE;
                    end
                end
            end
            default: state_d = ARB_IDLE;
        endcase
    end

    always_comb begin
        out_write_d = pop;
        out_din_d   = pop ? head_data : out_din_q;
        out_src_d   = pop ? gnt_q : out_src_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ARB_IDLE;
            gnt_q       <= '0;
            rr_ptr_q    <= '0;
            beat_cnt_q  <= '0;
            out_write_q <= 1'b0;
            out_din_q   <= '0;
            out_src_q   <= '0;
        end else begin
            state_q     <= state_d;
            gnt_q       <= gnt_d;
            rr_ptr_q    <= rr_ptr_d;
            beat_cnt_q  <= beat_cnt_d;
            out_write_q <= out_write_d;
            out_din_q   <= out_din_d;
            out_src_q   <= out_src_d;
        end
    end

    assign out_write = out_write_q;
    assign out_din   = out_din_q;
    assign out_src   = out_src_q;

endmodule

// File: tb/tb_relay_rr_arbiter.sv
// Directed and random bench for relay_rr_arbiter with FWFT source queues and a beat scoreboard.
module tb_relay_rr_arbiter;
    import relay_arb_pkg::*;

    localparam int NUM_SRC    = 4;
    localparam int DATA_WIDTH = 32;
    localparam int MAX_BURST  = 4;
    localparam int SRC_W      = 2;
    localparam int BEAT_W     = SRC_W + DATA_WIDTH;

    logic                          clk = 1'b0;
    logic                          rst;
    logic [NUM_SRC-1:0]            in_empty_n;
    logic [NUM_SRC-1:0]            in_read;
    logic [NUM_SRC*DATA_WIDTH-1:0] in_dout;
    logic                          out_full_n;
    logic                          out_write;
    logic [DATA_WIDTH-1:0]         out_din;
    logic [SRC_W-1:0]              out_src;

    always #5 clk = ~clk;

    relay_rr_arbiter #(
        .NUM_SRC    (NUM_SRC),
        .DATA_WIDTH (DATA_WIDTH),
        .MAX_BURST  (MAX_BURST)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .in_empty_n (in_empty_n),
        .in_read    (in_read),
        .in_dout    (in_dout),
        .out_full_n (out_full_n),
        .out_write  (out_write),
        .out_din    (out_din),
        .out_src    (out_src)
    );

    logic [DATA_WIDTH-1:0] src_q [NUM_SRC][$];
    logic [BEAT_W-1:0]     exp_q [$];
    int                    checks = 0;
    int                    errors = 0;
    int                    seq    = 0;
    logic [NUM_SRC-1:0]    last_rd;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic load(input int s, input int n);
        for (int k = 0; k < n; k++) begin
            src_q[s].push_back((32'(s) << 24) | 32'(seq));
            seq++;
        end
    endtask

    task automatic drive_srcs();
        for (int i = 0; i < NUM_SRC; i++) begin
            in_empty_n[i] = (src_q[i].size() != 0);
            in_dout[i*DATA_WIDTH +: DATA_WIDTH] = (src_q[i].size() != 0) ? src_q[i][0] : '0;
        end
    endtask

    // One clock: present sources, observe pops, advance, then score the registered beat.
    task automatic cycle();
        logic [NUM_SRC-1:0] rd;
        drive_srcs();
        #1;
        rd = in_read;
        check("rd_onehot0", 64'($countones(rd) <= 1), 64'(1));
        if (!out_full_n || rst) check("rd_blocked", 64'(rd), 64'(0));
        for (int i = 0; i < NUM_SRC; i++) begin
            if (rd[i]) begin
                if (src_q[i].size() == 0) check("pop_empty", 64'(1), 64'(0));
                else exp_q.push_back({SRC_W'(i), src_q[i][0]});
            end
        end
        @(posedge clk);
        for (int i = 0; i < NUM_SRC; i++) begin
            if (rd[i] && src_q[i].size() != 0) void'(src_q[i].pop_front());
        end
        #1;
        check("out_write_lag", 64'(out_write), 64'(|rd));
        if (out_write) begin
            if (exp_q.size() == 0) check("sb_spurious", 64'(1), 64'(0));
            else check("sb_beat", 64'({out_src, out_din}), 64'(exp_q.pop_front()));
        end
        last_rd = rd;
    endtask

    task automatic cyc_exp(input string tag, input logic [NUM_SRC-1:0] exp_rd);
        cycle();
        check(tag, 64'(last_rd), 64'(exp_rd));
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cycle();
        cycle();
        rst = 1'b0;
    endtask

    function automatic bit busy();
        bit b;
        b = (exp_q.size() != 0) || (dut.state_q != ARB_IDLE);
        for (int i = 0; i < NUM_SRC; i++) begin
            if (src_q[i].size() != 0) b = 1'b1;
        end
        return b;
    endfunction

    task automatic drain(input string tag);
        int n;
        n = 0;
        out_full_n = 1'b1;
        while (busy() && n < 400) begin
            cycle();
            n++;
        end
        check({tag, "_drained"}, 64'(busy()), 64'(0));
    endtask

    initial begin
        rst        = 1'b1;
        out_full_n = 1'b1;
        in_empty_n = '0;
        in_dout    = '0;
        last_rd    = '0;

        do_reset();
        check("rst_state", 64'(dut.state_q), 64'(ARB_IDLE));
        check("rst_gnt", 64'(dut.gnt_q), 64'(0));
        check("rst_rr_ptr", 64'(dut.rr_ptr_q), 64'(0));
        check("rst_beat_cnt", 64'(dut.beat_cnt_q), 64'(0));
        check("rst_out_write", 64'(out_write), 64'(0));
        check("rst_out_din", 64'(out_din), 64'(0));
        check("rst_out_src", 64'(out_src), 64'(0));

        // Single source, 6 beats: burst of 4 then an immediate regrant of the same source.
        load(2, 6);
        cyc_exp("t1_idle", 4'b0000);
        for (int k = 0; k < 6; k++) begin
            cyc_exp("t1_pop", 4'b0100);
            if (k == 3) begin
                check("t1_cnt_wrap", 64'(dut.beat_cnt_q), 64'(0));
                check("t1_rr_ptr_mid", 64'(dut.rr_ptr_q), 64'(3));
                check("t1_regrant", 64'(dut.gnt_q), 64'(2));
            end
        end
        cyc_exp("t1_dry", 4'b0000);
        check("t1_state", 64'(dut.state_q), 64'(ARB_IDLE));
        check("t1_rr_ptr", 64'(dut.rr_ptr_q), 64'(3));

        // All sources valid: 0,1,2,3,0 in back-to-back 4-beat bursts.
        do_reset();
        for (int s = 0; s < NUM_SRC; s++) load(s, 8);
        cyc_exp("t2_idle", 4'b0000);
        for (int k = 0; k < 20; k++) begin
            cyc_exp("t2_grant", 4'(1 << ((k / 4) % 4)));
        end
        drain("t2");

        // Sink stall at beat 2 of a src0 burst.
        do_reset();
        load(0, 8);
        load(1, 4);
        cyc_exp("t3_idle", 4'b0000);
        cyc_exp("t3_b0", 4'b0001);
        cyc_exp("t3_b1", 4'b0001);
        out_full_n = 1'b0;
        for (int k = 0; k < 5; k++) begin
            cyc_exp("t3_stall", 4'b0000);
            check("t3_cnt_frozen", 64'(dut.beat_cnt_q), 64'(2));
            check("t3_gnt_held", 64'(dut.gnt_q), 64'(0));
        end
        out_full_n = 1'b1;
        cyc_exp("t3_b2", 4'b0001);
        cyc_exp("t3_b3", 4'b0001);
        cyc_exp("t3_src1", 4'b0010);
        drain("t3");

        // Release on empty switches straight to the next waiting source.
        do_reset();
        load(1, 1);
        load(3, 3);
        cyc_exp("t4_idle", 4'b0000);
        cyc_exp("t4_src1", 4'b0010);
        cyc_exp("t4_release", 4'b0000);
        check("t4_gnt", 64'(dut.gnt_q), 64'(3));
        check("t4_state", 64'(dut.state_q), 64'(ARB_BURST));
        check("t4_rr_ptr", 64'(dut.rr_ptr_q), 64'(2));
        for (int k = 0; k < 3; k++) cyc_exp("t4_src3", 4'b1000);
        cyc_exp("t4_dry", 4'b0000);
        check("t4_idle_end", 64'(dut.state_q), 64'(ARB_IDLE));
        drain("t4");

        // Reset during the third beat of a src2 burst.
        do_reset();
        load(1, 1);
        load(2, 6);
        cyc_exp("t5_idle", 4'b0000);
        cyc_exp("t5_src1", 4'b0010);
        cyc_exp("t5_switch", 4'b0000);
        check("t5_rr_ptr_pre", 64'(dut.rr_ptr_q), 64'(2));
        cyc_exp("t5_b0", 4'b0100);
        cyc_exp("t5_b1", 4'b0100);
        rst = 1'b1;
        cyc_exp("t5_rst", 4'b0000);
        rst = 1'b0;
        check("t5_out_write", 64'(out_write), 64'(0));
        check("t5_rr_ptr", 64'(dut.rr_ptr_q), 64'(0));
        check("t5_state", 64'(dut.state_q), 64'(ARB_IDLE));
        check("t5_beat_cnt", 64'(dut.beat_cnt_q), 64'(0));
        drain("t5");

        // Random arrivals and sink back-pressure against the scoreboard.
        do_reset();
        for (int k = 0; k < 10000; k++) begin
            for (int s = 0; s < NUM_SRC; s++) begin
                if ($urandom_range(0, 3) == 0 && src_q[s].size() < 8) load(s, 1);
            end
            out_full_n = ($urandom_range(0, 3) != 0);
            cycle();
        end
        drain("t6");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
